// File: rtl/pal_pkg.sv
// pal_pkg: shared definitions for the PAL configuration loader.
//   - default PAL geometry (inputs, outputs, product stages)
//   - pal_bitstream_len(): configuration bitstream length for a geometry
//   - loader_state_t: loader FSM encoding, also used by the bench for coverage
package pal_pkg;

    localparam int PAL_N_DEFAULT = 4;
    localparam int PAL_M_DEFAULT = 1;
    localparam int PAL_P_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_SHIFT_LO  = 3'd2,
        ST_SHIFT_HI  = 3'd3,
        ST_FINISH    = 3'd4
    } loader_state_t;

    // Two literal columns (true/complement) per input per product term,
    // plus one OR-plane bit per product term per output.
    function automatic int pal_bitstream_len(input int n, input int m, input int p);
        return 2 * n * p + p * m;
    endfunction

endpackage

// File: rtl/pal_cfg_piso.sv
// pal_cfg_piso: parallel-load, shift-right register holding one bitstream word.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (clears the register)
//   load  : capture d (has priority over shift)
//   shift : shift right by one, zero fill at the top
//   d     : parallel word
//   q0    : current LSB (next bit to serialise)
module pal_cfg_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q0
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= {1'b0, sr[WORD_W-1:1]};
        end
    end

    assign q0 = sr[0];

endmodule

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: streams the PAL configuration bitstream onto PAL.CLK/PAL.CFG.
// Words arrive over DATA_IN/DATA_VALID/DATA_READY and are serialised LSB first,
// two CLK cycles per bit (CFG set up in a low cycle, CLK high in the next).
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-high reset
//   START      : one-cycle load request, honoured only in IDLE
//   DATA_IN    : bitstream word, bit 0 = lowest remaining bitstream index
//   DATA_VALID : DATA_IN valid
//   DATA_READY : loader accepts a word this cycle
//   PAL_CLK    : configuration clock to the PAL
//   PAL_CFG    : configuration data to the PAL
//   BUSY       : load in progress
//   DONE       : one-cycle pulse after the last bit
//   DBG_STATE  : current FSM state, for observation only
//
// Handshake: a word transfers on a rising CLK edge where DATA_VALID and
// DATA_READY are both 1. DATA_READY is only ever 1 in WAIT_WORD; DATA_VALID in
// any other state is ignored and the word stays with the producer.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int N      = PAL_N_DEFAULT,
    parameter int M      = PAL_M_DEFAULT,
    parameter int P      = PAL_P_DEFAULT,
    parameter int WORD_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [WORD_W-1:0] DATA_IN,
    input  logic              DATA_VALID,
    output logic              DATA_READY,
    output logic              PAL_CLK,
    output logic              PAL_CFG,
    output logic              BUSY,
    output logic              DONE,
    output loader_state_t     DBG_STATE
);

    localparam int LEN  = pal_bitstream_len(N, M, P);
    localparam int BS_W = $clog2(LEN + 1);
    localparam int WB_W = $clog2(WORD_W + 1);

    loader_state_t   state;
    logic [BS_W-1:0] bits_sent;
    logic [WB_W-1:0] word_bits;
    logic [BS_W-1:0] bits_left;
    logic [WB_W-1:0] next_word_bits;
    logic            sr_load;
    logic            sr_shift;
    logic            sr_q0;

    // The final word may carry fewer useful bits than WORD_W.
    assign bits_left      = BS_W'(LEN) - bits_sent;
    assign next_word_bits = (int'(bits_left) < WORD_W) ? WB_W'(bits_left) : WB_W'(WORD_W);

    assign sr_load  = (state == ST_WAIT_WORD) && DATA_VALID && DATA_READY;
    // The register shifts as SHIFT_LO ends: the current bit is already held in
    // the PAL_CFG flop, and q0 then presents the next bit for the SHIFT_HI exit.
    assign sr_shift = (state == ST_SHIFT_LO);

    pal_cfg_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .clk   (CLK),
        .rst   (RST),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (DATA_IN),
        .q0    (sr_q0)
    );

    // Every output is a flop set on the edge that enters the state which
    // defines it, so PAL_CLK/PAL_CFG never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            bits_sent  <= '0;
            word_bits  <= '0;
            DATA_READY <= 1'b0;
            PAL_CLK    <= 1'b0;
            PAL_CFG    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state      <= ST_WAIT_WORD;
                        BUSY       <= 1'b1;
                        DATA_READY <= 1'b1;
                    end
                end

                ST_WAIT_WORD: begin
                    // Stalls here with PAL_CLK low and PAL_CFG holding.
                    if (DATA_VALID) begin
                        state      <= ST_SHIFT_LO;
                        DATA_READY <= 1'b0;
                        PAL_CFG    <= DATA_IN[0];
                        word_bits  <= next_word_bits;
                    end
                end

                ST_SHIFT_LO: begin
                    state   <= ST_SHIFT_HI;
                    PAL_CLK <= 1'b1;
                end

                ST_SHIFT_HI: begin
                    PAL_CLK <= 1'b0;
                    if (bits_sent == BS_W'(LEN - 1)) begin
                        state     <= ST_FINISH;
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        PAL_CFG   <= 1'b0;
                        bits_sent <= '0;
                        word_bits <= '0;
                    end else begin
                        bits_sent <= bits_sent + 1'b1;
                        word_bits <= word_bits - 1'b1;
                        if (word_bits == WB_W'(1)) begin
                            state      <= ST_WAIT_WORD;
                            DATA_READY <= 1'b1;
                        end else begin
                            state   <= ST_SHIFT_LO;
                            PAL_CFG <= sr_q0;
                        end
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign DBG_STATE = state;

endmodule
